// File: rtl/multiport_regfile.sv
// multiport_regfile: parametrised register file with same-cycle write bypass, optional zero register
// and a clear sequencer that zeroes one entry per cycle after reset or on clr_req.
module multiport_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1,
    parameter bit BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     init_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     wr_conflict,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              ready;
    logic              conflict;
    logic [NUM_WR-1:0] eff;

    assign ready     = rst && state == READY;
    assign init_busy = state == INIT;

    genvar k;
    generate
        for (k = 0; k < NUM_WR; k++) begin : g_eff
            assign eff[k] = ready && wr_en[k] && !(ZERO_REG && wr_addr[k*ADDR_W +: ADDR_W] == '0);
        end
    endgenerate

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
                if (eff[i] && eff[j] && wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])
                    conflict = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= INIT;
            clr_ptr     <= '0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= conflict;
            if (state == INIT) begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
                if (&clr_ptr) state <= READY;
            end else if (clr_req) begin
                state   <= INIT;
                clr_ptr <= '0;
            end
        end
    end

    // ascending port order lets the highest-index port win on a shared address
    always_ff @(posedge clk) begin
        if (rst && state == INIT)
            mem[clr_ptr] <= '0;
        else
            for (int i = 0; i < NUM_WR; i++)
                if (eff[i]) mem[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_data[j*DATA_W +: DATA_W] = mem[rd_addr[j*ADDR_W +: ADDR_W]];
            for (int i = 0; i < NUM_WR; i++)
                if (BYPASS && eff[i] && wr_addr[i*ADDR_W +: ADDR_W] == rd_addr[j*ADDR_W +: ADDR_W])
                    rd_data[j*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
            if (!ready || !rd_en[j] || (ZERO_REG && rd_addr[j*ADDR_W +: ADDR_W] == '0))
                rd_data[j*DATA_W +: DATA_W] = '0;
        end
    end
endmodule
